// File: rtl/parity_pkg.sv
// Shared types and constants for the parity-framed serial transmitter.
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned DATA_BITS  = 4;
  localparam int unsigned FRAME_BITS = 7;

endpackage

// File: rtl/parity4_gen.sv
// Combinational parity bit for a nibble: even parity when par_sel=0, odd when 1.
module parity4_gen
  import parity_pkg::*;
(
  input  logic [DATA_BITS-1:0] data,
  input  logic                 par_sel,
  output logic                 par
);

  always_comb begin
    par = (^data) ^ par_sel;
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Frames a nibble as start, 4 data bits LSB first, parity, stop; each bit held BIT_CYCLES clocks.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 par_sel,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned CW = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST     = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(BIT_CYCLES - 2);
  localparam logic [1:0]    LAST_IDX = 2'(DATA_BITS - 1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [1:0]             idx;
  logic [DATA_BITS-1:0]   data;
  logic                   sel;
  logic                   par;

  parity4_gen u_parity (
    .data    (data),
    .par_sel (sel),
    .par     (par)
  );

  // Outputs are loaded alongside the state change so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      data       <= '0;
      sel        <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      din_ready  <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid) begin
            data      <= din;
            sel       <= par_sel;
            state     <= START;
            cnt       <= '0;
            idx       <= '0;
            tx        <= 1'b0;
            busy      <= 1'b1;
            din_ready <= 1'b0;
          end
        end
        START: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DATA;
            tx    <= data[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= PARITY;
              tx    <= par;
            end else begin
              idx <= idx + 2'd1;
              tx  <= data[idx + 2'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            state      <= STOP;
            tx         <= 1'b1;
            // With one clock per bit the single STOP clock is also the last one.
            frame_done <= (BIT_CYCLES == 1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
            din_ready <= 1'b1;
          end else begin
            cnt        <= cnt + 1'b1;
            frame_done <= (cnt == PRE_LAST);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          idx       <= '0;
          tx        <= 1'b1;
          busy      <= 1'b0;
          din_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench: accepted nibbles queue expected frames; a monitor checks the serial line per clock.
module tb_parity_frame_tx;
  import parity_pkg::*;

  localparam int unsigned BC         = 4;
  localparam int unsigned FRAME_CLKS = FRAME_BITS * BC;

  typedef struct {
    logic [3:0]  d;
    logic        s;
    int unsigned start;
    bit          b2b;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       par_sel = 1'b0;
  logic       din_ready, tx, busy, frame_done;

  logic [3:0] din1 = '0;
  logic       din_valid1 = 1'b0;
  logic       par_sel1 = 1'b0;
  logic       din_ready1, tx1, busy1, frame_done1;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  bit          b2b = 1'b0;
  bit          in_frame = 1'b0;
  bit          done1 = 1'b0;
  frame_t      exp_q[$];

  parity_frame_tx #(.BIT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .par_sel(par_sel), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  parity_frame_tx #(.BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1), .din_ready(din_ready1),
    .par_sel(par_sel1), .tx(tx1), .busy(busy1), .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer a nibble and wait (bounded) for the handshake; returns #1 after the transfer edge.
  task automatic send(input logic [3:0] d, input logic s);
    bit ok;
    ok = 1'b0;
    din = d;
    par_sel = s;
    din_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (din_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: din_ready stayed 0 for 200 cycles, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  // Record every accepted nibble together with the cycle its START must appear.
  initial forever begin
    @(negedge clk);
    if (!rst && din_valid && din_ready) exp_q.push_back('{din, par_sel, cyc + 1, b2b});
  end

  // Monitor: reference frame = {stop, parity, d[3:0], start}, each bit held BC clocks.
  initial begin
    frame_t      e;
    int unsigned k;
    int unsigned last_end;
    logic [6:0]  bits;
    logic        p;
    bit          post;
    k = 0;
    last_end = 0;
    bits = '0;
    post = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        post = 1'b0;
      end else if (in_frame || busy) begin
        if (!in_frame) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: busy=1 with nothing accepted at cycle %0d, required busy=0", cyc);
          end else begin
            e = exp_q.pop_front();
            check("start_cycle", cyc, e.start);
            if (e.b2b) check("b2b_gap", cyc - last_end, 2);
            p = 1'(($countones(e.d) + int'(e.s)) % 2);
            bits = {1'b1, p, e.d, 1'b0};
            in_frame = 1'b1;
            k = 0;
          end
        end
        if (in_frame) begin
          check("tx_bit", tx, bits[k / BC]);
          check("busy_in_frame", busy, 1);
          check("ready_in_frame", din_ready, 0);
          check("frame_done", frame_done, (k == FRAME_CLKS - 1));
          k++;
          if (k == FRAME_CLKS) begin
            in_frame = 1'b0;
            post = 1'b1;
            last_end = cyc;
          end
        end
      end else begin
        check("done_idle", frame_done, 0);
        if (post) begin
          check("ready_idle", din_ready, 1);
          check("tx_idle", tx, 1);
          post = 1'b0;
        end
      end
    end
  end

  // One-clock-per-bit instance: directed 0110 odd-parity frame.
  initial begin
    logic [6:0] exp1;
    exp1 = 7'b1101100;
    wait (rst == 1'b0);
    @(posedge clk);
    #1;
    din1 = 4'b0110;
    par_sel1 = 1'b1;
    din_valid1 = 1'b1;
    @(negedge clk);
    check("bc1_ready", din_ready1, 1);
    @(posedge clk);
    #1;
    din_valid1 = 1'b0;
    din1 = 4'b1001;
    par_sel1 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("bc1_tx", tx1, exp1[k]);
      check("bc1_busy", busy1, 1);
      check("bc1_done", frame_done1, (k == 6));
    end
    @(negedge clk);
    check("bc1_idle_busy", busy1, 0);
    check("bc1_idle_tx", tx1, 1);
    check("bc1_idle_ready", din_ready1, 1);
    done1 = 1'b1;
  end

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !in_frame) break;
      @(negedge clk);
    end
    check("queue_drained", exp_q.size(), 0);
    check("frame_closed", in_frame, 0);
  endtask

  initial begin
    repeat (2) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_ready", din_ready, 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(4'b1011, 1'b0);
    din_valid = 1'b0;
    din = 4'b0100;
    par_sel = 1'b1;
    send(4'b0000, 1'b1);
    din_valid = 1'b0;
    send(4'b1111, 1'b0);
    din_valid = 1'b0;

    // valid pulsed mid-DATA must be ignored
    repeat (8) @(posedge clk);
    #1;
    din_valid = 1'b1;
    din = 4'b0001;
    par_sel = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ready_during_data", din_ready, 0);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    drain();

    send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    b2b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 4'($urandom_range(0, 15));
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    b2b = 1'b0;
    din_valid = 1'b0;
    drain();

    for (int i = 0; i < 8; i++) begin
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      din_valid = 1'b0;
      din = 4'($urandom_range(0, 15));
      par_sel = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();

    // abort in PARITY (clocks 20..23 of the frame)
    send(4'b1101, 1'b1);
    din_valid = 1'b0;
    repeat (21) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_done", frame_done, 0);
    check("abort_ready", din_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(4'b0110, 1'b0);
    din_valid = 1'b0;
    drain();

    for (int i = 0; i < 100 && !done1; i++) @(negedge clk);
    check("bc1_finished", done1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
